// File: rtl/wb_ifetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding and counter sizing.
package wb_ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int DEPTH_DEF = 4;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int CW = cnt_width(DEPTH_DEF);

endpackage

// File: rtl/wb_ifetch_fifo_fwft.sv
// First-word-fall-through FIFO: head visible in the cycle empty deasserts.
// Zero-cycle read latency; a push at full is only legal together with a pop.
module fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_dat,
   input  logic                   pop,
   input  logic                   clear,
   output logic [WIDTH-1:0]       pop_dat,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNTW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & !empty & !clear;
   assign do_push = push & !clear & (!full | do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CNTW'(do_push) - CNTW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !clear));

endmodule

// File: rtl/wb_ifetch.sv
// Pipelined Wishbone read master streaming sequential ROM words into a prefetch FIFO.
// Accept-to-ins_valid is 2 cycles with a zero-wait slave; issue stops when FIFO+in-flight reaches DEPTH.
module wb_ifetch
   import wb_ifetch_pkg::*;
#(
   parameter int            AW        = 12,
   parameter int            DEPTH     = DEPTH_DEF,
   parameter logic [AW-1:0] RESET_ADR = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_adr,
   output logic [15:0]   ins,
   output logic [AW-1:0] ins_adr,
   output logic          ins_valid,
   input  logic          ins_ready,
   output logic          wb_cyc,
   output logic          wb_stb,
   output logic          wb_we,
   output logic [AW-1:0] wb_adr,
   input  logic [15:0]   wb_dat_i,
   input  logic          wb_ack,
   input  logic          wb_stall
);

   localparam int OW = cnt_width(DEPTH);

   state_t          state;
   logic [AW-1:0]   adr_q;
   logic [AW-1:0]   redir_q;
   logic            redir_pend;
   logic            pend_q;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;
   logic [OW-1:0]   out_next;
   logic [OW-1:0]   disc_flush;
   logic            accept;
   logic            ack;
   logic            credit;
   logic            live;
   logic            stall_hold;

   logic [OW-1:0]    dat_count;
   logic             dat_full;
   logic             dat_empty;
   logic [16+AW-1:0] dat_head;
   logic [OW-1:0]    tag_count;
   logic             tag_full;
   logic             tag_empty;
   logic [AW-1:0]    tag_head;

   assign wb_cyc = (state != IDLE);
   assign wb_we  = 1'b0;
   assign wb_adr = adr_q;

   // A stalled request stays on the bus no matter what en or credit do.
   always_comb begin
      wb_stb = 1'b0;
      case (state)
         FETCH:   wb_stb = pend_q | (en & credit);
         FLUSH:   wb_stb = pend_q;
         default: wb_stb = 1'b0;
      endcase
   end

   assign accept     = wb_stb & !wb_stall;
   assign ack        = wb_ack & wb_cyc;
   assign stall_hold = wb_stb & wb_stall;
   assign credit     = (int'(dat_count) + int'(outstanding)) < DEPTH;
   assign out_next   = outstanding + OW'(accept) - OW'(ack);
   assign disc_flush = discard + OW'(accept) - OW'(ack);
   assign live       = (state == FETCH) & !redirect;

   assign ins       = dat_head[AW +: 16];
   assign ins_adr   = dat_head[AW-1:0];
   assign ins_valid = !dat_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         adr_q       <= RESET_ADR;
         redir_q     <= RESET_ADR;
         redir_pend  <= 1'b0;
         pend_q      <= 1'b0;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= out_next;
         pend_q      <= stall_hold;
         if (redirect) begin
            discard <= out_next;
            // A request still stalled on the bus keeps its address; the new target waits behind it.
            if (stall_hold) begin
               redir_pend <= 1'b1;
               redir_q    <= redirect_adr;
            end else begin
               redir_pend <= 1'b0;
               adr_q      <= redirect_adr;
            end
            if (out_next != '0 || stall_hold) state <= FLUSH;
            else if (en)                      state <= FETCH;
            else                              state <= IDLE;
         end else begin
            if (accept) begin
               if (redir_pend) begin
                  adr_q      <= redir_q;
                  redir_pend <= 1'b0;
               end else begin
                  adr_q <= adr_q + AW'(1);
               end
            end
            case (state)
               IDLE:  if (en) state <= FETCH;
               FETCH: if (!en && !wb_stb && out_next == '0) state <= IDLE;
               FLUSH: begin
                  discard <= disc_flush;
                  if (disc_flush == '0 && !stall_hold) state <= FETCH;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   fifo_fwft #(.WIDTH(16 + AW), .DEPTH(DEPTH)) u_dat_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (ack & live),
      .push_dat ({wb_dat_i, tag_head}),
      .pop      (ins_ready),
      .clear    (redirect),
      .pop_dat  (dat_head),
      .full     (dat_full),
      .empty    (dat_empty),
      .count    (dat_count)
   );

   fifo_fwft #(.WIDTH(AW), .DEPTH(DEPTH)) u_tag_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (accept & live),
      .push_dat (adr_q),
      .pop      (ack & live),
      .clear    (redirect),
      .pop_dat  (tag_head),
      .full     (tag_full),
      .empty    (tag_empty),
      .count    (tag_count)
   );

   a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
      (state == FETCH) |-> (tag_count == outstanding));
   a_tag_on_ack: assert property (@(posedge clk) disable iff (!rst_n)
      (ack && live) |-> !tag_empty);
   a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
      (accept && live) |-> (!tag_full || ack));
   a_full_no_credit: assert property (@(posedge clk) disable iff (!rst_n)
      dat_full |-> !credit);

endmodule
